// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types for the SM83 M-cycle bus engine
// Contents:
//   mem_op_t    : MEM_NONE / MEM_READ / MEM_WRITE bus operation of one M-cycle
//   idu_op_t    : IDU_INC / IDU_DEC / IDU_NONE address adjust
//   eng_state_t : IDLE / ACTIVE engine state
package sm83_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDU_INC  = 2'd0,
    IDU_DEC  = 2'd1,
    IDU_NONE = 2'd2
  } idu_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } eng_state_t;

endpackage

// File: rtl/sm83_mcycle_engine_if.sv
// rtl/sm83_mcycle_engine_if.sv - request/response/memory bundle of the M-cycle engine
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wdata/req_idu : request from the sequencer
//   rsp_valid/rsp_rdata/rsp_idu_addr/rsp_err              : M-cycle completion
//   mem_addr/mem_wdata/mem_rd/mem_wr/mem_rdata/mem_ready  : memory bus
//   tstate                                                : current T-state index
// Modports: slave = engine, master = sequencer plus memory side.
interface sm83_mcycle_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TS_W   = 2
);
  import sm83_pkg::*;

  logic              req_valid;
  logic              req_ready;
  mem_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  idu_op_t           req_idu;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_idu_addr;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [TS_W-1:0]   tstate;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_idu, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_idu_addr, rsp_err,
           mem_addr, mem_wdata, mem_rd, mem_wr, tstate
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_idu, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_idu_addr, rsp_err,
           mem_addr, mem_wdata, mem_rd, mem_wr, tstate
  );

endinterface

// File: rtl/sm83_idu.sv
// rtl/sm83_idu.sv - combinational increment/decrement unit
// Ports:
//   op     in  idu_op_t  IDU_INC / IDU_DEC / IDU_NONE
//   addr   in  ADDR_W    input address
//   result out ADDR_W    addr +1 / -1 / +0, modulo 2^ADDR_W
module sm83_idu
  import sm83_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  idu_op_t           op,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] result
);

  always_comb begin
    result = addr;
    case (op)
      IDU_INC: result = addr + 1'b1;
      IDU_DEC: result = addr - 1'b1;
      default: result = addr;
    endcase
  end

endmodule

// File: rtl/sm83_mcycle_engine.sv
// rtl/sm83_mcycle_engine.sv - one memory M-cycle of T_PER_M T-states per accepted request
// Ports:
//   clk    in  clock, all logic on posedge
//   rst_n  in  synchronous active-low reset
//   bus    sm83_mcycle_engine_if.slave (request, response, memory bus, tstate)
// Optional feature: SM83_WAIT_TIMEOUT_EN aborts a cycle after MAX_WAIT wait states
// with rsp_err=1 and rsp_rdata all ones; undefined, waits are unbounded.
module sm83_mcycle_engine
  import sm83_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int T_PER_M  = 4,
  parameter int MAX_WAIT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  sm83_mcycle_engine_if.slave bus
);

  localparam int              TS_W   = $clog2(T_PER_M);
  localparam logic [TS_W-1:0] T_LAST = TS_W'(T_PER_M - 1);

  eng_state_t        state;
  logic [TS_W-1:0]   tstate;
  mem_op_t           op_q;
  idu_op_t           idu_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] idu_rsp_q;
  logic              rd_q;
  logic              wr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic [ADDR_W-1:0] idu_addr;
  logic              final_t;
  logic              timeout;
  logic              done;
  logic              req_ready;
  logic              accept;

  sm83_idu #(.ADDR_W(ADDR_W)) u_idu (
    .op     (idu_q),
    .addr   (addr_q),
    .result (idu_addr)
  );

  assign final_t = (state == ACTIVE) && (tstate == T_LAST);

`ifdef SM83_WAIT_TIMEOUT_EN
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  logic [WC_W-1:0] wait_cnt;
  // wait_cnt already holds MAX_WAIT stalled clocks: this clock aborts instead of stalling again.
  assign timeout = (op_q != MEM_NONE) && !bus.mem_ready && (wait_cnt == WC_W'(MAX_WAIT));
`else
  // MAX_WAIT is a non-negative count, so this is constant false: no abort path.
  assign timeout = (MAX_WAIT < 0);
`endif

  // MEM_NONE never looks at mem_ready and always finishes in T_PER_M clocks.
  assign done      = final_t && ((op_q == MEM_NONE) || bus.mem_ready || timeout);
  // Ready in the completing final T-state gives back-to-back cycles with no bubble.
  assign req_ready = (state == IDLE) || done;
  assign accept    = bus.req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tstate      <= '0;
      op_q        <= MEM_NONE;
      idu_q       <= IDU_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      idu_rsp_q   <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef SM83_WAIT_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (state == ACTIVE) begin
        if (tstate != T_LAST) begin
          tstate <= tstate + 1'b1;
          rd_q   <= (op_q == MEM_READ);
          wr_q   <= (op_q == MEM_WRITE);
        end else if (done) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= timeout;
          idu_rsp_q   <= idu_addr;
          if (timeout) begin
            rdata_q <= '1;
          end else if (op_q == MEM_READ) begin
            rdata_q <= bus.mem_rdata;
          end
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          state  <= IDLE;
          tstate <= '0;
        end
`ifdef SM83_WAIT_TIMEOUT_EN
        else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
`endif
      end
      // Placed last so an accept in the completing final T-state overrides the return to IDLE.
      if (accept) begin
        state   <= ACTIVE;
        tstate  <= '0;
        op_q    <= bus.req_op;
        idu_q   <= bus.req_idu;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
`ifdef SM83_WAIT_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_idu_addr = idu_rsp_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_rd       = rd_q;
  assign bus.mem_wr       = wr_q;
  assign bus.tstate       = tstate;

endmodule
